// File: rtl/wb_select_unit_pkg.sv
// wb_select_unit_pkg: shared CPU constants for the writeback select unit
package wb_select_unit_pkg;
   localparam logic [1:0] ST_INIT = 2'd0;
   localparam logic [1:0] ST_IDLE = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_COMMIT = 2'd3;
   localparam int DEF_RESET_SP = 227;
   localparam int DEF_SP_IDX = 29;
   function automatic int spSelCode(input int numSrc);
      return numSrc;
   endfunction
endpackage

// File: rtl/wb_wait_timer.sv
// wb_wait_timer: saturating wait counter with timeout detection
module wb_wait_timer #(
   parameter int MAX_WAIT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic tick,
   output logic expired
);
   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (!reset || clear) cnt <= '0;
      else if (tick && cnt != CNT_W'(MAX_WAIT)) cnt <= cnt + 1'b1;
   end
   assign expired = tick && cnt == CNT_W'(MAX_WAIT - 1);
endmodule

// File: rtl/wb_select_unit.sv
// wb_select_unit: writeback source select with ready wait, timeout and post-reset SP write
module wb_select_unit
   import wb_select_unit_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NUM_SRC = 7,
   parameter int RESET_SP = DEF_RESET_SP,
   parameter int SP_IDX = DEF_SP_IDX,
   parameter int MAX_WAIT = 64,
   localparam int SEL_W = $clog2(NUM_SRC + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req,
   input  logic [SEL_W-1:0]          sel,
   input  logic [4:0]                dest,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic [NUM_SRC-1:0]        src_ready,
   output logic [DATA_W-1:0]         wb_data,
   output logic [4:0]                wb_dest,
   output logic                      wb_we,
   output logic                      busy,
   output logic                      err
);
   localparam logic [SEL_W-1:0] SP_SEL = SEL_W'(spSelCode(NUM_SRC));
   logic [1:0] state, nextState;
   logic [SEL_W-1:0] selQ, useSel;
   logic [NUM_SRC:0] readyExt;
   logic [(NUM_SRC+1)*DATA_W-1:0] dataExt;
   logic legal, newReq, selReady, take, tick, expired;
   // the RESET_SP constant rides as an always-ready extra slot
   assign readyExt = {1'b1, src_ready};
   assign dataExt = {DATA_W'(RESET_SP), src_data};
   always_comb begin
      legal = sel <= SP_SEL;
      newReq = state == ST_IDLE && req;
      useSel = state == ST_WAIT ? selQ : sel;
      selReady = readyExt[useSel];
      take = (newReq && legal && selReady) || (state == ST_WAIT && selReady);
      tick = state == ST_WAIT && !selReady;
      nextState = state == ST_INIT ? ST_COMMIT :
                  state == ST_COMMIT ? ST_IDLE :
                  take ? ST_COMMIT :
                  (newReq && legal) ? ST_WAIT :
                  (state == ST_WAIT && !expired) ? ST_WAIT : ST_IDLE;
   end
   wb_wait_timer #(.MAX_WAIT(MAX_WAIT)) waitTimer (
      .clk(clk),
      .reset(reset),
      .clear(state != ST_WAIT),
      .tick(tick),
      .expired(expired)
   );
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= ST_INIT;
         wb_data <= DATA_W'(RESET_SP);
         wb_dest <= 5'(SP_IDX);
         selQ <= '0;
         err <= 1'b0;
      end else begin
         state <= nextState;
         err <= (newReq && !legal) || expired;
         if (take) wb_data <= dataExt[useSel*DATA_W +: DATA_W];
         if (newReq && legal) begin
            selQ <= sel;
            wb_dest <= dest;
         end
      end
   end
   assign wb_we = state == ST_COMMIT && wb_dest != 5'd0;
   assign busy = state != ST_IDLE;
endmodule

// File: tb/tb_wb_select_unit.sv
// tb_wb_select_unit: randomized transaction-level check of wb_select_unit
module tb_wb_select_unit;
   localparam int DATA_W = 32;
   localparam int NUM_SRC = 7;
   localparam int RESET_SP = 227;
   localparam int SP_IDX = 29;
   localparam int MAX_WAIT = 64;
   localparam int SEL_W = $clog2(NUM_SRC + 1);
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic req = 1'b0;
   logic [SEL_W-1:0] sel = '0;
   logic [4:0] dest = '0;
   logic [NUM_SRC*DATA_W-1:0] src_data = '0;
   logic [NUM_SRC-1:0] src_ready = '0;
   logic [DATA_W-1:0] wb_data;
   logic [4:0] wb_dest;
   logic wb_we, busy, err;
   int nChecks = 0;
   int nFails = 0;
   logic [31:0] lastData;
   logic [4:0] lastDest;
   always #5 clk = ~clk;
   wb_select_unit #(
      .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .RESET_SP(RESET_SP), .SP_IDX(SP_IDX), .MAX_WAIT(MAX_WAIT)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .sel(sel), .dest(dest), .src_data(src_data),
      .src_ready(src_ready), .wb_data(wb_data), .wb_dest(wb_dest), .wb_we(wb_we), .busy(busy), .err(err)
   );
   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic cycleCheck(input string tag, input bit b, input bit w, input bit e);
      checkVal({tag, " busy"}, 32'(busy), 32'(b));
      checkVal({tag, " we"}, 32'(wb_we), 32'(w));
      checkVal({tag, " err"}, 32'(err), 32'(e));
      checkVal({tag, " data"}, wb_data, lastData);
      checkVal({tag, " dest"}, 32'(wb_dest), 32'(lastDest));
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic randomizeSrc();
      for (int i = 0; i < NUM_SRC; i++) src_data[i*DATA_W +: DATA_W] = $urandom;
      src_ready = NUM_SRC'($urandom);
   endtask
   task automatic doReset(input int n);
      reset = 1'b0;
      req = 1'b0;
      repeat (n) step();
      lastData = RESET_SP;
      lastDest = 5'(SP_IDX);
      cycleCheck("reset", 1, 0, 0);
      reset = 1'b1;
      step();
      cycleCheck("sp write", 1, 1, 0);
      step();
      cycleCheck("sp idle", 0, 0, 0);
   endtask
   task automatic doTxn(input int s, input int dst, input int d, input logic [31:0] val);
      int readyC, commitC, lastC, busyCnt;
      bit illegal, timeout, expBusy, expErr, expWe;
      string tag;
      illegal = s > NUM_SRC;
      timeout = !illegal && s != NUM_SRC && d >= MAX_WAIT;
      readyC = timeout ? 1 << 30 : (s == NUM_SRC || d == 0) ? 0 : d + 1;
      commitC = readyC + 1;
      lastC = illegal ? 1 : timeout ? MAX_WAIT + 1 : commitC + 1;
      randomizeSrc();
      req = 1'b1;
      sel = SEL_W'(s);
      dest = 5'(dst);
      if (s < NUM_SRC) begin
         src_ready[s] = readyC == 0;
         if (readyC == 0) src_data[s*DATA_W +: DATA_W] = val;
      end
      busyCnt = 0;
      for (int c = 1; c <= lastC; c++) begin
         step();
         expBusy = !illegal && (timeout ? c <= MAX_WAIT : c <= commitC);
         expErr = (illegal && c == 1) || (timeout && c == MAX_WAIT + 1);
         expWe = !illegal && !timeout && c == commitC && dst != 0;
         if (!illegal && c == 1) lastDest = 5'(dst);
         if (!illegal && !timeout && c == commitC) lastData = s == NUM_SRC ? RESET_SP : val;
         tag = $sformatf("sel%0d dst%0d d%0d c%0d", s, dst, d, c);
         cycleCheck(tag, expBusy, expWe, expErr);
         busyCnt += int'(busy);
         randomizeSrc();
         if (s < NUM_SRC && c <= readyC) begin
            src_ready[s] = c == readyC;
            if (c == readyC) src_data[s*DATA_W +: DATA_W] = val;
         end
         req = expBusy && $urandom_range(0, 1) == 1;
         sel = SEL_W'($urandom);
         dest = 5'($urandom);
      end
      req = 1'b0;
      if (!illegal) checkVal({tag, " busy cycles"}, busyCnt, timeout ? MAX_WAIT : commitC);
   endtask
   initial begin
      int s, dst, d, r;
      doReset(3);
      doTxn(0, 8, 0, 32'h1234);
      doTxn(2, 4, 5, 32'hDEAD);
      doTxn(3, 6, MAX_WAIT, 32'h0);
      doTxn(NUM_SRC, 0, 0, 32'h0);
      doTxn(1, 12, MAX_WAIT - 1, $urandom);
      doTxn(4, 0, 3, $urandom);
      randomizeSrc();
      req = 1'b1;
      sel = 3'd2;
      dest = 5'd5;
      src_ready[2] = 1'b0;
      repeat (4) begin
         step();
         req = 1'b0;
         src_ready[2] = 1'b0;
         checkVal("mid-wait busy", 32'(busy), 1);
         checkVal("mid-wait we", 32'(wb_we), 0);
      end
      doReset(1);
      repeat (60) begin
         s = $urandom_range(0, NUM_SRC);
         dst = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31);
         r = $urandom_range(0, 9);
         d = r < 4 ? 0 : r < 8 ? $urandom_range(1, 8) : r == 8 ? MAX_WAIT - 1 : MAX_WAIT;
         doTxn(s, dst, d, $urandom);
      end
      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
      $finish;
   end
endmodule
